// File: rtl/instr_packer.sv
// rtl/instr_packer.sv - packs decoded CU fields into 53-bit words, buffers them with program addresses, streams to instruction memory
module instr_packer #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [PC_W-1:0] base_addr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_last,
    input  logic [15:0]     data_bus_1,
    input  logic [15:0]     data_bus_2,
    input  logic [3:0]      opcode,
    input  logic            load_immediate,
    input  logic            read_write,
    input  logic [4:0]      addr1,
    input  logic [4:0]      addr2,
    input  logic [4:0]      addr3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [52:0]     out_word,
    output logic [PC_W-1:0] out_addr,
    output logic            busy,
    output logic            done,
    output logic            pc_wrap
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t          state, state_nx;
    logic [52:0]     mem_word [DEPTH];
    logic [PC_W-1:0] mem_addr [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [PC_W-1:0] pc;
    logic [52:0]     last_word;
    logic [PC_W-1:0] last_addr;
    logic [52:0]     packed_word;
    logic            empty, full, push, pop;

    assign packed_word = {data_bus_1, data_bus_2, opcode, load_immediate, read_write,
                          addr1, addr2, addr3};

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign in_ready  = (state == S_LOAD) && !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    // Outputs keep showing the most recently popped entry while the FIFO is empty.
    assign out_word = empty ? last_word : mem_word[rd_ptr];
    assign out_addr = empty ? last_addr : mem_addr[rd_ptr];

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD:  if (push && in_last) state_nx = S_DRAIN;
            S_DRAIN: if (empty || (count == (AW+1)'(1) && pop)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_word[wr_ptr] <= packed_word;
            mem_addr[wr_ptr] <= pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pc        <= '0;
            pc_wrap   <= 1'b0;
            last_word <= '0;
            last_addr <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                pc      <= base_addr;
                pc_wrap <= 1'b0;
            end else if (push) begin
                pc <= pc + 1'b1;
                if (pc == '1) pc_wrap <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_word <= mem_word[rd_ptr];
                last_addr <= mem_addr[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_packer.sv
// tb/tb_instr_packer.sv - randomized and directed bench for instr_packer against a queue-based reference model
module tb_instr_packer;
    localparam int DEPTH = 4;
    localparam int PC_W  = 8;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [15:0] data_bus_1 = '0, data_bus_2 = '0;
    logic [3:0]  opcode = '0;
    logic        load_immediate = 1'b0, read_write = 1'b0;
    logic [4:0]  addr1 = '0, addr2 = '0, addr3 = '0;
    logic        in_ready, out_valid, busy, done, pc_wrap;
    logic [52:0] out_word;
    logic [7:0]  out_addr;

    int n_chk = 0, n_pass = 0;

    instr_packer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .data_bus_1(data_bus_1), .data_bus_2(data_bus_2), .opcode(opcode),
        .load_immediate(load_immediate), .read_write(read_write),
        .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_addr(out_addr), .busy(busy), .done(done), .pc_wrap(pc_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: field weights by arithmetic, program flow as a queue and a phase number.
    function automatic logic [52:0] pack_ref();
        longint unsigned w;
        w = longint'(data_bus_1) * (64'd1 << 37) + longint'(data_bus_2) * (64'd1 << 21)
          + longint'(opcode) * 64'd131072 + longint'(load_immediate) * 64'd65536
          + longint'(read_write) * 64'd32768 + longint'(addr1) * 64'd1024
          + longint'(addr2) * 64'd32 + longint'(addr3);
        return w[52:0];
    endfunction

    logic [60:0] mq[$];
    int          m_phase = 0;
    logic [7:0]  m_pc = '0;
    logic        m_wrap = 1'b0;
    logic [52:0] m_lw = '0;
    logic [7:0]  m_la = '0;
    int          pre_phase, pre_size;
    bit          do_push, do_pop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_phase = 0; m_pc = '0; m_wrap = 1'b0; m_lw = '0; m_la = '0;
        end else begin
            pre_phase = m_phase;
            pre_size  = mq.size();
            do_push   = (pre_phase == 1) && in_valid && (pre_size < DEPTH);
            do_pop    = (pre_size > 0) && out_ready;
            if (do_pop) {m_lw, m_la} = mq.pop_front();
            if (do_push) begin
                mq.push_back({pack_ref(), m_pc});
                if (m_pc == 8'hFF) m_wrap = 1'b1;
                m_pc = m_pc + 8'd1;
            end
            case (pre_phase)
                0: if (start) begin m_phase = 1; m_pc = base_addr; m_wrap = 1'b0; end
                1: if (do_push && in_last) m_phase = 2;
                2: if (mq.size() == 0) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("out_valid", out_valid, mq.size() != 0);
        chk("in_ready", in_ready, (m_phase == 1) && (mq.size() < DEPTH));
        chk("busy", busy, m_phase != 0);
        chk("done", done, m_phase == 3);
        chk("pc_wrap", pc_wrap, m_wrap);
        if (mq.size() != 0) begin
            chk("out_word", out_word, mq[0][60:8]);
            chk("out_addr", out_addr, mq[0][7:0]);
        end else begin
            chk("out_word_hold", out_word, m_lw);
            chk("out_addr_hold", out_addr, m_la);
        end
    end

    task automatic rand_fields();
        data_bus_1 = 16'($urandom); data_bus_2 = 16'($urandom);
        opcode = 4'($urandom); load_immediate = 1'($urandom); read_write = 1'($urandom);
        addr1 = 5'($urandom); addr2 = 5'($urandom); addr3 = 5'($urandom);
    endtask

    task automatic start_prog(input logic [7:0] b);
        @(posedge clk); #1 start = 1'b1; base_addr = b;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", k < limit, 1);
        if (k < limit) begin
            chk("done_after_drain", out_valid, 0);
            @(negedge clk);
            chk("done_one_cycle", done, 0);
        end
    endtask

    task automatic run_rand(input logic [7:0] b, input int n, input int pv, input int pr, input bit restart);
        int  sent = 0, cyc = 0;
        bit  rdy, restarted = 0;
        start_prog(b);
        in_valid = ($urandom % 100) < pv; rand_fields(); in_last = (n == 1);
        out_ready = ($urandom % 100) < pr;
        while (sent < n && cyc < 2000) begin
            @(negedge clk) rdy = in_ready;
            @(posedge clk);
            if (in_valid && rdy) sent++;
            cyc++;
            #1 start = 1'b0;
            if (restart && !restarted && sent == 1 && n >= 3) begin
                start = 1'b1; base_addr = 8'($urandom); restarted = 1;
            end
            if (sent < n) begin
                in_valid = ($urandom % 100) < pv; rand_fields(); in_last = (sent == n - 1);
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            out_ready = ($urandom % 100) < pr;
        end
        chk("load_progress", sent, n);
        out_ready = 1'b1;
        wait_done(100);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single word with literal packing
        start_prog(8'h10);
        data_bus_1 = 16'hABCD; data_bus_2 = 16'h1234; opcode = 4'h5;
        load_immediate = 1'b1; read_write = 1'b0; addr1 = 5'd1; addr2 = 5'd2; addr3 = 5'd3;
        in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b0;
        @(negedge clk) chk("t2_in_ready", in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("t2_word", out_word, 53'h1579A2468B0443);
        chk("t2_addr", out_addr, 8'h10);
        chk("t2_d1", out_word[52:37], 16'hABCD);
        chk("t2_d2", out_word[36:21], 16'h1234);
        chk("t2_op", out_word[20:17], 4'h5);
        chk("t2_li", out_word[16], 1);
        chk("t2_rw", out_word[15], 0);
        chk("t2_a1", out_word[14:10], 5'd1);
        chk("t2_a2", out_word[9:5], 5'd2);
        chk("t2_a3", out_word[4:0], 5'd3);
        out_ready = 1'b1;
        wait_done(20);

        // Reset in the middle of a load
        out_ready = 1'b0;
        start_prog(8'h33);
        in_valid = 1'b1; rand_fields();
        @(posedge clk); #1 rand_fields();
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("t1_busy", busy, 0); chk("t1_out_valid", out_valid, 0);
        chk("t1_in_ready", in_ready, 0); chk("t1_done", done, 0);
        chk("t1_word", out_word, 0); chk("t1_addr", out_addr, 0);
        @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk) chk("t1_no_done", done, 0);

        // Backpressure fills the FIFO
        start_prog(8'h40);
        in_valid = 1'b1; in_last = 1'b0;
        for (int k = 0; k < 4; k++) begin rand_fields(); @(posedge clk); #1; end
        @(negedge clk);
        chk("t3_full_ready", in_ready, 0); chk("t3_head", out_addr, 8'h40);
        in_last = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk) chk("t3_second", out_addr, 8'h41);
        @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk) chk("t3_third", out_addr, 8'h42);
        wait_done(20);

        // Address wrap
        out_ready = 1'b0;
        start_prog(8'hFE);
        in_valid = 1'b1; rand_fields();
        @(posedge clk); #1 rand_fields();
        @(negedge clk) chk("t4_wrap_pre", pc_wrap, 0);
        @(posedge clk); #1 rand_fields(); in_last = 1'b1;
        @(negedge clk) chk("t4_wrap_set", pc_wrap, 1);
        @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(negedge clk) chk("t4_a0", out_addr, 8'hFE);
        @(negedge clk) chk("t4_a1", out_addr, 8'hFF);
        @(negedge clk) chk("t4_a2", out_addr, 8'h00);
        wait_done(20);
        chk("t4_wrap_held", pc_wrap, 1);
        start_prog(8'h20);
        @(negedge clk) chk("t4_wrap_clr", pc_wrap, 0);
        in_valid = 1'b1; in_last = 1'b1; rand_fields();
        @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
        wait_done(20);

        // Streaming: one word per cycle, each word visible for exactly one cycle
        start_prog(8'h80);
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rand_fields(); in_last = (i == 15);
            @(negedge clk);
            chk("t6_in_ready", in_ready, 1);
            if (i > 0) chk("t6_addr", out_addr, 8'(8'h80 + i - 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        wait_done(20);

        // Randomized programs, some with an ignored mid-load start
        for (int p = 0; p < 24; p++) begin
            run_rand((p % 3 == 0) ? 8'(8'hF8 + $urandom_range(0, 7)) : 8'($urandom),
                     $urandom_range(1, 12), $urandom_range(30, 100),
                     $urandom_range(20, 100), (p % 2) == 1);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end
endmodule
